// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared state encoding and default sizes for the CPU step controller.
package cpu_ctrl_pkg;
    localparam int DEBOUNCE_CYCLES_DEF = 20000;
    localparam int CNT_W_DEF = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STEP = 2'd2, HALTED = 2'd3} state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronizes and debounces the step button, pulsing step_req_o on each press.
module btn_debounce import cpu_ctrl_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic step_req_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_lvl, r_lvl_d;
    logic          w_diff, w_done;
    assign w_diff = r_sync[1] ^ r_lvl;
    assign w_done = r_cnt == CW'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_lvl   <= 1'b0;
            r_lvl_d <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], btn_i};
            r_lvl_d <= r_lvl;
            r_cnt   <= (!w_diff || w_done) ? '0 : r_cnt + 1'b1;
            if (w_diff && w_done) r_lvl <= ~r_lvl;
        end
    end
    // only presses request a step; releases are filtered but silent
    assign step_req_o = r_lvl & ~r_lvl_d;
endmodule

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: gates CPU advance pulses from the slow tick in free-run or single-step mode.
module cpu_step_ctrl import cpu_ctrl_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             btn_step,
    input  logic             mode_run,
    input  logic             halt_i,
    output logic             cpu_en,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] step_count
);
    state_t           r_state, w_next;
    logic [2:0]       r_tick;
    logic             r_en, w_en, w_rise, w_req;
    logic [CNT_W-1:0] r_cnt;
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
        .clk(clk), .reset(reset), .btn_i(btn_step), .step_req_o(w_req)
    );
    // r_tick[1:0] is the synchronizer, r_tick[2] the history flop
    assign w_rise = r_tick[1] & ~r_tick[2];
    always_comb begin
        w_next = r_state;
        w_en   = 1'b0;
        case (r_state)
            IDLE: w_next = mode_run ? RUN : (w_req ? STEP : IDLE);
            RUN: begin
                w_en   = w_rise & ~halt_i;
                w_next = halt_i ? HALTED : (mode_run ? RUN : IDLE);
            end
            STEP: begin
                w_en   = w_rise & ~halt_i;
                w_next = halt_i ? HALTED : (w_rise ? IDLE : STEP);
            end
            default: w_next = HALTED;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_tick  <= '0;
            r_en    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_tick  <= {r_tick[1:0], tick_i};
            r_en    <= w_en;
            if (r_en && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
        end
    end
    assign cpu_en     = r_en;
    assign state_o    = r_state;
    assign step_count = r_cnt;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// tb_cpu_step_ctrl: randomized scoreboard bench against an edge-indexed reference model.
module tb_cpu_step_ctrl;
    localparam int D = 4;
    localparam int W = 4;
    localparam int MAXC = (1 << W) - 1;
    localparam int N = 16384;

    logic clk = 0, reset = 1, tick_i = 0, btn_step = 0, mode_run = 0, halt_i = 0;
    logic cpu_en;
    logic [1:0] state_o;
    logic [W-1:0] step_count;

    cpu_step_ctrl #(.DEBOUNCE_CYCLES(D), .CNT_W(W)) dut (
        .clk(clk), .reset(reset), .tick_i(tick_i), .btn_step(btn_step),
        .mode_run(mode_run), .halt_i(halt_i), .cpu_en(cpu_en),
        .state_o(state_o), .step_count(step_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at edge", name, act, exp);
        end
    endtask

    typedef struct {int c; int n;} exp_t;
    exp_t pq[$];
    int   sq[$];

    // reference model: inputs sampled per edge, decisions from those sample histories
    int cyc = 0, last_rst = 0, ms = 0, mcnt = 0;
    bit men = 0, mlvl = 0, m_req = 0;
    bit t_s[0:N-1];
    bit b_s[0:N-1];

    function automatic bit tv(int i);
        return (i < 0 || i <= last_rst) ? 1'b0 : t_s[i];
    endfunction
    function automatic bit bv(int i);
        return (i < 0 || i <= last_rst) ? 1'b0 : b_s[i];
    endfunction

    initial begin
        bit rise, req, flip;
        int nx;
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc >= N - 1) begin
                $display("FAIL watchdog edges=%0d limit=%0d", cyc, N - 1);
                $fatal(1);
            end
            t_s[cyc] = tick_i;
            b_s[cyc] = btn_step;
            if (reset) begin
                ms = 0; men = 0; mcnt = 0; mlvl = 0; m_req = 0; last_rst = cyc;
            end else begin
                // tick seen high two edges ago after being low three edges ago
                rise = tv(cyc - 2) && !tv(cyc - 3);
                req  = m_req;
                if (men && mcnt < MAXC) mcnt++;
                men = (ms == 1 || ms == 2) && rise && !halt_i;
                if (men) pq.push_back('{cyc, mcnt});
                nx = ms;
                if (ms == 0) nx = mode_run ? 1 : (req ? 2 : 0);
                else if (ms == 1) nx = halt_i ? 3 : (mode_run ? 1 : 0);
                else if (ms == 2) nx = halt_i ? 3 : (rise ? 0 : 2);
                ms = nx;
                // level flips once D consecutive synced samples disagree with it
                flip = 1;
                for (int k = 0; k < D; k++) if (bv(cyc - 2 - k) == mlvl) flip = 0;
                m_req = flip && !mlvl;
                if (flip) mlvl = !mlvl;
            end
            sq.push_back(ms);
        end
    end

    // monitor: compares every observed cycle against the scoreboard queues
    initial begin
        exp_t e;
        bit xe;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) chk("state_o", state_o, sq.pop_front());
            xe = (pq.size() > 0) && (pq[0].c == cyc);
            chk("cpu_en", cpu_en, xe);
            if (xe) begin
                e = pq.pop_front();
                if (cpu_en) chk("step_count", step_count, e.n);
            end
        end
    end

    task automatic wait_n(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1;
        @(negedge clk);
        reset = 0;
        chk("rst_state", state_o, 0);
        chk("rst_cpu_en", cpu_en, 0);
        chk("rst_count", step_count, 0);
    endtask

    task automatic ticks(int n, int lo, int hi);
        for (int i = 0; i < n; i++) begin
            tick_i = 1;
            wait_n($urandom_range(hi, lo));
            tick_i = 0;
            wait_n($urandom_range(hi, lo));
        end
    endtask

    initial begin
        wait_n(3);
        do_reset();
        // free run
        mode_run = 1;
        ticks(4, 10, 10);
        ticks(4, 3, 12);
        chk("run_count", step_count, mcnt);
        // single step with a bouncing press
        do_reset();
        mode_run = 0;
        wait_n(4);
        btn_step = 1; wait_n(1);
        btn_step = 0; wait_n(1);
        btn_step = 1; wait_n(10);
        btn_step = 0; wait_n(10);
        chk("step_wait_state", state_o, 2);
        ticks(3, 6, 10);
        chk("step_done_state", state_o, 0);
        chk("step_one_pulse", step_count, 1);
        // reset while a step is pending
        btn_step = 1;
        for (int i = 0; i < 30 && ms != 2; i++) @(negedge clk);
        chk("step_entered", state_o, 2);
        do_reset();
        btn_step = 0;
        wait_n(10);
        // step request coinciding with mode_run
        btn_step = 1;
        for (int i = 0; i < 30 && !m_req; i++) @(negedge clk);
        chk("req_seen", m_req, 1);
        mode_run = 1;
        wait_n(4);
        chk("coincide_run", state_o, 1);
        btn_step = 0;
        ticks(3, 5, 9);
        // random mix
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(5) == 0) tick_i = ~tick_i;
            if ($urandom_range(9) == 0) btn_step = ~btn_step;
            if ($urandom_range(99) == 0) mode_run = ~mode_run;
            reset = ($urandom_range(399) == 0);
            @(negedge clk);
        end
        reset = 0;
        tick_i = 0;
        btn_step = 0;
        wait_n(4);
        // saturation
        do_reset();
        mode_run = 1;
        ticks(20, 10, 10);
        chk("saturated", step_count, MAXC);
        // halt coinciding with a tick rise
        do_reset();
        mode_run = 1;
        ticks(3, 6, 8);
        tick_i = 1;
        wait_n(2);
        halt_i = 1;
        wait_n(5);
        chk("halted_state", state_o, 3);
        chk("halted_count", step_count, 3);
        halt_i = 0;
        tick_i = 0;
        wait_n(4);
        ticks(3, 5, 8);
        mode_run = 0;
        btn_step = 1; wait_n(12);
        btn_step = 0;
        ticks(2, 5, 8);
        chk("halt_sticky", state_o, 3);
        chk("halt_count_hold", step_count, 3);
        wait_n(3);
        chk("pending_empty", pq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 20000, clk cycles btn_step must be stable before its debounced level changes (min 2).
REQ-002 SHALL have parameter: CNT_W, 16, width of step_count.
REQ-003 SHALL have port: clk  input  1  system clock; the only clock; every flop on its rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: tick_i  input  1  divided slow clock from the clock divider, treated as asynchronous data.
REQ-006 SHALL have port: btn_step  input  1  raw single-step push button, asynchronous, bouncy.
REQ-007 SHALL have port: mode_run  input  1  switch; 1 = free-run, 0 = single-step.
REQ-008 SHALL have port: halt_i  input  1  CPU halt indication, synchronous to clk.
REQ-009 SHALL have port: cpu_en  output  1  one-clk-cycle CPU advance pulse, registered.
REQ-010 SHALL have port: state_o  output  2  current FSM state encoding.
REQ-011 SHALL have port: step_count  output  CNT_W  number of cpu_en pulses since reset.

Function
REQ-012 SHALL pass tick_i through a 2-flop synchronizer plus a history flop; tick_rise = sync2 AND NOT history.
REQ-013 SHALL give cpu_en a latency of 3 clk edges: the edge that first samples tick_i high counts as edge 1, and cpu_en is high after edge 3 (RUN state, no halt).
REQ-014 SHALL pass btn_step through a 2-flop synchronizer, then debounce: a counter increments while synced input != debounced level, clears when they are equal, and the debounced level flips when the count reaches DEBOUNCE_CYCLES-1.
REQ-015 SHALL generate step_req as a one-cycle pulse on the debounced level's rising edge only; release produces no request.
REQ-016 SHALL implement FSM states IDLE=0, RUN=1, STEP=2, HALTED=3, driven on state_o.
REQ-017 IDLE: cpu_en=0; mode_run=1 -> RUN; else step_req -> STEP; else stay.
REQ-018 RUN: cpu_en <= tick_rise; halt_i -> HALTED; else mode_run=0 -> IDLE.
REQ-019 STEP: wait for tick_rise, emit exactly one cpu_en, then -> IDLE; halt_i -> HALTED.
REQ-020 HALTED: cpu_en=0; leave only via reset.
REQ-021 SHALL give halt_i priority over every other event; when halt_i and tick_rise coincide, no cpu_en is emitted.
REQ-022 SHALL give mode_run=1 priority over step_req in IDLE; the coinciding step_req is dropped.
REQ-023 SHALL ignore step_req in RUN, STEP and HALTED, without queueing it.
REQ-024 SHALL increment step_count on every cycle cpu_en is high, saturating at all-ones without wrap.
REQ-025 SHALL allow cpu_en to be high for at most one cycle per tick_rise.

Reset
REQ-026 SHALL reset on a reset=1 clk edge: FSM=IDLE, cpu_en=0, step_count=0, all synchronizer/history flops=0, debounce counter=0, debounced level=0.
REQ-027 SHALL abort any pending STEP or debounce in progress on mid-operation reset; the first tick_rise after reset requires a fresh low-to-high tick_i.

Structure
REQ-028 SHALL place the state enum (IDLE/RUN/STEP/HALTED) and the DEBOUNCE_CYCLES/CNT_W defaults in shared package cpu_ctrl_pkg.
REQ-029 SHALL implement the synchronizer and debounce counter in one sub-module, btn_debounce, that outputs the step_req pulse; tick synchronization stays inline.

Verification (DEBOUNCE_CYCLES=4, CNT_W=4)
REQ-030 mode_run=1, tick_i toggling every 10 clk -> cpu_en one cycle high on the 3rd edge after each tick_i rise; step_count 0,1,2,... .
REQ-031 mode_run=0, btn_step bounces 1-0-1 within 3 clk then held high 10 clk -> exactly one STEP entry; one cpu_en on the next tick_rise; state_o returns to 0.
REQ-032 RUN, halt_i=1 on the same cycle as tick_rise -> no cpu_en; state_o=3; further ticks and steps produce nothing until reset.
REQ-033 RUN for 20 ticks -> step_count saturates at 15 and holds.
REQ-034 IDLE, step_req and mode_run=1 on the same cycle -> RUN, no extra STEP pulse; reset asserted while in STEP -> state_o=0, cpu_en=0, step_count=0 on the next edge.
